// File: rtl/wb_uart_pkg.sv
// Shared constants and FSM encoding for the serial-to-Wishbone bridge.
package wb_uart_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_e;

endpackage

// File: rtl/wb_uart_master_uart.sv
// 8N1 UART core: single-byte receive holding register with framing-error
// flag, and a transmit shifter. Bit timing is clk_freq/baud cycles per bit.
module wb_uart_master_uart #(
  parameter int unsigned clk_freq = 50000000,
  parameter int unsigned baud     = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic       txd_o,
  output logic [7:0] rx_data_o,
  output logic       rx_avail_o,
  output logic       rx_error_o,
  input  logic       rx_ack_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_wr_i,
  output logic       tx_busy_o
);

  localparam int unsigned DIV = clk_freq / baud;
  localparam int unsigned CW  = $clog2(DIV) + 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  logic [2:0]    rxd_sync_q;
  logic          rx_busy_q;
  logic [CW-1:0] rx_tick_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic [7:0]    rx_data_q;
  logic          rx_avail_q;
  logic          rx_error_q;

  logic          tx_busy_q;
  logic [CW-1:0] tx_tick_q;
  logic [3:0]    tx_bit_q;
  logic [9:0]    tx_sh_q;

  logic rx_in;
  logic rx_fall;

  assign rx_in   = rxd_sync_q[1];
  assign rx_fall = rxd_sync_q[2] & ~rxd_sync_q[1];

  assign rx_data_o  = rx_data_q;
  assign rx_avail_o = rx_avail_q;
  assign rx_error_o = rx_error_q;
  assign tx_busy_o  = tx_busy_q;
  assign txd_o      = tx_busy_q ? tx_sh_q[0] : 1'b1;

  // Receiver: start-bit edge, centre sampling, stop bit sets the error flag when low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxd_sync_q <= '1;
      rx_busy_q  <= 1'b0;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_avail_q <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      rxd_sync_q <= {rxd_sync_q[1:0], rxd_i};
      if (rx_ack_i) begin
        rx_avail_q <= 1'b0;
        rx_error_q <= 1'b0;
      end
      if (!rx_busy_q) begin
        if (rx_fall) begin
          rx_busy_q <= 1'b1;
          rx_tick_q <= HALF_M1;
          rx_bit_q  <= '0;
        end
      end else if (rx_tick_q != '0) begin
        rx_tick_q <= rx_tick_q - 1'b1;
      end else begin
        rx_tick_q <= DIV_M1;
        if (rx_bit_q == 4'd0) begin
          if (rx_in) rx_busy_q <= 1'b0;
          else       rx_bit_q  <= 4'd1;
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_q  <= 1'b0;
          rx_data_q  <= rx_sh_q;
          rx_avail_q <= 1'b1;
          rx_error_q <= ~rx_in;
        end else begin
          rx_sh_q  <= {rx_in, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 1'b1;
        end
      end
    end
  end

  // Transmitter: start, 8 data bits LSB first, stop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_busy_q <= 1'b0;
      tx_tick_q <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
    end else if (!tx_busy_q) begin
      if (tx_wr_i) begin
        tx_sh_q   <= {1'b1, tx_data_i, 1'b0};
        tx_busy_q <= 1'b1;
        tx_tick_q <= DIV_M1;
        tx_bit_q  <= '0;
      end
    end else if (tx_tick_q != '0) begin
      tx_tick_q <= tx_tick_q - 1'b1;
    end else begin
      tx_tick_q <= DIV_M1;
      tx_sh_q   <= {1'b1, tx_sh_q[9:1]};
      if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
      else                  tx_bit_q  <= tx_bit_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_uart_master.sv
// Serial-to-Wishbone bridge: decodes framed host commands from the UART and
// issues single 32-bit Wishbone cycles, answering with ACK/NAK or read data.
module wb_uart_master
  import wb_uart_pkg::*;
#(
  parameter int unsigned clk_freq   = 50000000,
  parameter int unsigned baud       = 115200,
  parameter int unsigned wb_timeout = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int unsigned TW = $clog2(wb_timeout) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(wb_timeout - 1);

  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  logic [7:0] rx_data;
  logic       rx_avail, rx_error, tx_busy;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          blank_q, blank_d;
  logic          we_r_q, we_r_d;
  logic [31:0]   adr_r_q, adr_r_d;
  logic [31:0]   dat_r_q, dat_r_d;
  logic [31:0]   txbuf_q, txbuf_d;
  logic [2:0]    rsp_cnt_q, rsp_cnt_d;
  logic          rsp_nak_q, rsp_nak_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          rx_ack_q, rx_ack_d;
  logic          tx_wr_q, tx_wr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          cyc_q, cyc_d;
  logic          wb_we_q, wb_we_d;
  logic [31:0]   wb_adr_q, wb_adr_d;
  logic [31:0]   wb_dat_q, wb_dat_d;
  logic [3:0]    wb_sel_q, wb_sel_d;

  logic rx_take;
  logic start_bus;

  // Reset synchroniser: asserts immediately, releases two clocks after reset rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  // The UART shares the synchronised reset so both sides leave reset together.
  wb_uart_master_uart #(
    .clk_freq(clk_freq),
    .baud    (baud)
  ) uart0 (
    .clk_i     (clk),
    .rst_i     (~rst_n_int),
    .rxd_i     (uart_rxd),
    .txd_o     (uart_txd),
    .rx_data_o (rx_data),
    .rx_avail_o(rx_avail),
    .rx_error_o(rx_error),
    .rx_ack_i  (rx_ack_q),
    .tx_data_i (tx_data_q),
    .tx_wr_i   (tx_wr_q),
    .tx_busy_o (tx_busy)
  );

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = wb_we_q;
  assign wb_adr_o = wb_adr_q;
  assign wb_sel_o = wb_sel_q;
  assign wb_dat_o = wb_dat_q;

  // Framing FSM, bus cycle control and response sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blank_d   = 1'b0;
    we_r_d    = we_r_q;
    adr_r_d   = adr_r_q;
    dat_r_d   = dat_r_q;
    txbuf_d   = txbuf_q;
    rsp_cnt_d = rsp_cnt_q;
    rsp_nak_d = rsp_nak_q;
    timer_d   = timer_q;
    rx_ack_d  = 1'b0;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    cyc_d     = cyc_q;
    wb_we_d   = wb_we_q;
    wb_adr_d  = wb_adr_q;
    wb_dat_d  = wb_dat_q;
    wb_sel_d  = wb_sel_q;
    start_bus = 1'b0;

    // rx_ack is registered, so the cycle after a take is blank to avoid re-reading the same byte.
    rx_take = rx_avail && !blank_q &&
              (state_q == ST_IDLE || state_q == ST_ADDR || state_q == ST_DATA);

    if (rx_take) begin
      rx_ack_d = 1'b1;
      blank_d  = 1'b1;
      if (rx_error) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              we_r_d  = (rx_data == CMD_WR);
              cnt_d   = '0;
              state_d = ST_ADDR;
            end
          end
          ST_ADDR: begin
            adr_r_d = {adr_r_q[23:0], rx_data};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == 2'd3) begin
              if (we_r_q) state_d = ST_DATA;
              else        start_bus = 1'b1;
            end
          end
          ST_DATA: begin
            dat_r_d = {dat_r_q[23:0], rx_data};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == 2'd3) start_bus = 1'b1;
          end
          default: ;
        endcase
      end
    end

    if (start_bus) begin
      state_d  = ST_BUS;
      cyc_d    = 1'b1;
      wb_we_d  = we_r_q;
      wb_adr_d = adr_r_d;
      wb_dat_d = dat_r_d;
      wb_sel_d = '1;
      timer_d  = '0;
    end

    if (state_q == ST_BUS) begin
      if (wb_ack_i) begin
        cyc_d     = 1'b0;
        rsp_nak_d = 1'b0;
        rsp_cnt_d = we_r_q ? 3'd1 : 3'd4;
        if (!we_r_q) txbuf_d = wb_dat_i;
        state_d   = ST_RESP;
      end else if (timer_q == T_LAST) begin
        cyc_d     = 1'b0;
        rsp_nak_d = 1'b1;
        rsp_cnt_d = 3'd1;
        state_d   = ST_RESP;
      end else if (timer_q != '1) begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (state_q == ST_RESP && !tx_busy && !blank_q) begin
      tx_wr_d   = 1'b1;
      blank_d   = 1'b1;
      tx_data_d = rsp_nak_q ? RSP_NAK : (we_r_q ? RSP_ACK : txbuf_q[31:24]);
      txbuf_d   = {txbuf_q[23:0], 8'h00};
      rsp_cnt_d = rsp_cnt_q - 1'b1;
      if (rsp_cnt_q == 3'd1) state_d = ST_IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      blank_q   <= 1'b0;
      we_r_q    <= 1'b0;
      adr_r_q   <= '0;
      dat_r_q   <= '0;
      txbuf_q   <= '0;
      rsp_cnt_q <= '0;
      rsp_nak_q <= 1'b0;
      timer_q   <= '0;
      rx_ack_q  <= 1'b0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= '0;
      cyc_q     <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_adr_q  <= '0;
      wb_dat_q  <= '0;
      wb_sel_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blank_q   <= blank_d;
      we_r_q    <= we_r_d;
      adr_r_q   <= adr_r_d;
      dat_r_q   <= dat_r_d;
      txbuf_q   <= txbuf_d;
      rsp_cnt_q <= rsp_cnt_d;
      rsp_nak_q <= rsp_nak_d;
      timer_q   <= timer_d;
      rx_ack_q  <= rx_ack_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
      cyc_q     <= cyc_d;
      wb_we_q   <= wb_we_d;
      wb_adr_q  <= wb_adr_d;
      wb_dat_q  <= wb_dat_d;
      wb_sel_q  <= wb_sel_d;
    end
  end

endmodule

// File: tb/tb_wb_uart_master.sv
// Scoreboard bench for wb_uart_master: stimulus queues expected bus cycles and
// host-bound bytes; independent monitors pop and compare as the DUT produces them.
module tb_wb_uart_master;

  localparam int unsigned TMO  = 64;
  localparam int          BITC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        ack;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          len;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  bit         noack = 1'b0;
  bit         tx_mon_busy = 1'b0;

  always #5 clk = ~clk;

  wb_uart_master #(
    .clk_freq  (1600000),
    .baud      (100000),
    .wb_timeout(TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rxd(uart_rxd),
    .uart_txd(uart_txd),
    .wb_cyc_o(cyc),
    .wb_stb_o(stb),
    .wb_we_o (we),
    .wb_adr_o(adr),
    .wb_sel_o(sel),
    .wb_dat_o(dat_o),
    .wb_dat_i(dat_i),
    .wb_ack_i(ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wishbone slave with 2-cycle ack latency; noack suppresses the acknowledge.
  int lat;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack <= 1'b0; lat <= 0; dat_i <= '0;
    end else if (ack) begin
      ack <= 1'b0; lat <= 0;
    end else if (cyc && stb && !noack) begin
      if (lat == 1) begin
        ack   <= 1'b1;
        dat_i <= (adr == 32'h0000_0200) ? 32'h1234_5678 : 32'hA5A5_A5A5;
        lat   <= 0;
      end else lat <= lat + 1;
    end else lat <= 0;
  end

  // Bus monitor: compare each cycle's attributes and, where given, its length.
  bit   cyc_prev = 1'b0;
  int   cyc_len = 0;
  bus_t cur;
  bit   cur_valid = 1'b0;
  always @(negedge clk) begin
    if (cyc && !cyc_prev) begin
      cyc_len = 0;
      if (exp_bus.size() == 0) begin
        checks++; errors++; cur_valid = 1'b0;
        $display("FAIL unexpected_bus_cycle: got we=%b adr=%h, none required", we, adr);
      end else begin
        cur = exp_bus.pop_front();
        cur_valid = 1'b1;
        chk("bus_we", {31'd0, we}, {31'd0, cur.we});
        chk("bus_adr", adr, cur.adr);
        if (cur.we) chk("bus_dat", dat_o, cur.dat);
        chk("bus_sel", {28'd0, sel}, 32'hF);
        chk("bus_stb", {31'd0, stb}, 32'd1);
      end
    end
    if (cyc) cyc_len++;
    if (!cyc && cyc_prev && cur_valid && cur.len > 0) chk("bus_len", cyc_len, cur.len);
    cyc_prev = cyc;
  end

  // Host-side receiver: decode uart_txd and compare against expected bytes.
  logic [7:0] tx_b;
  logic       tx_stop;
  initial forever begin
    @(negedge clk);
    if (reset && uart_txd === 1'b0) begin
      tx_mon_busy = 1'b1;
      repeat (BITC / 2 - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BITC) @(negedge clk);
        tx_b[i] = uart_txd;
      end
      repeat (BITC) @(negedge clk);
      tx_stop = uart_txd;
      chk("tx_stop", {31'd0, tx_stop}, 32'd1);
      if (exp_tx.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_tx_byte: got %h, none required", tx_b);
      end else chk("tx_byte", {24'd0, tx_b}, {24'd0, exp_tx.pop_front()});
      tx_mon_busy = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BITC) @(negedge clk);
    end
    uart_rxd = ~bad_stop;
    repeat (BITC) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic write_frame(input logic [31:0] a, input logic [31:0] d);
    exp_bus.push_back('{1'b1, a, d, -1});
    exp_tx.push_back(8'h06);
    send_byte(8'h57, 1'b0);
    send_word(a);
    send_word(d);
  endtask

  task automatic read_frame(input logic [31:0] a, input logic [31:0] d, input int len);
    exp_bus.push_back('{1'b0, a, 32'h0, len});
    if (len > 0) exp_tx.push_back(8'h15);
    else begin
      exp_tx.push_back(d[31:24]); exp_tx.push_back(d[23:16]);
      exp_tx.push_back(d[15:8]);  exp_tx.push_back(d[7:0]);
    end
    send_byte(8'h52, 1'b0);
    send_word(a);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_bus.size() != 0 || exp_tx.size() != 0 || tx_mon_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL drain_%s: got bus=%0d tx=%0d outstanding, required 0", name, exp_bus.size(), exp_tx.size());
      exp_bus.delete(); exp_tx.delete();
    end
    repeat (300) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cyc"}, {31'd0, cyc}, 32'd0);
    chk({tag, "_stb"}, {31'd0, stb}, 32'd0);
    chk({tag, "_we"},  {31'd0, we},  32'd0);
    chk({tag, "_adr"}, adr, 32'd0);
    chk({tag, "_sel"}, {28'd0, sel}, 32'd0);
    chk({tag, "_dat"}, dat_o, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (4) @(negedge clk);
    chk_outputs_zero("rst");
    chk("rst_txd", {31'd0, uart_txd}, 32'd1);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    write_frame(32'h0000_0104, 32'hDEAD_BEEF);
    wait_drain("write");

    read_frame(32'h0000_0200, 32'h1234_5678, -1);
    wait_drain("read");

    noack = 1'b1;
    read_frame(32'h0000_0000, 32'h0, int'(TMO));
    wait_drain("timeout");
    noack = 1'b0;

    send_byte(8'h41, 1'b0);
    write_frame(32'h0000_0008, 32'h0102_0304);
    wait_drain("garbage");

    send_byte(8'h52, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (100) @(negedge clk);
    read_frame(32'h0000_0200, 32'h1234_5678, -1);
    wait_drain("frame_err");

    write_frame(32'h0000_0020, 32'h1122_3344);
    write_frame(32'h0000_0024, 32'h5566_7788);
    wait_drain("b2b");

    noack = 1'b1;
    exp_bus.push_back('{1'b0, 32'h0000_0200, 32'h0, -1});
    send_byte(8'h52, 1'b0);
    send_word(32'h0000_0200);
    n = 0;
    while (!cyc && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("cyc_before_reset", {31'd0, cyc}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_outputs_zero("midrst");
    repeat (5) @(negedge clk);
    noack = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    read_frame(32'h0000_0200, 32'h1234_5678, -1);
    wait_drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
